tw_ctrl: RTL and testbench

//  Time-set controller for the LED display twinkle datapath. Steps the user through HOUR -> MIN -> SEC

---
 rtl/tw_ctrl.sv | 70 +++++++
 tb/tb_tw_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tw_ctrl.sv
// tw_ctrl: time-set field sequencer with shared blink divider, idle timeout and adjust strobes.
module tw_ctrl #(
  parameter int TW_HALF = 25_000_000,
  parameter int TO_HALF = 20
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       key_set,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic       set_mode,
  output logic [1:0] adj_field,
  output logic       adj_up,
  output logic       adj_dn,
  output logic       twinkle,
  output logic [5:0] twinkle_led
);
  localparam int CW = $clog2(TW_HALF);
  localparam int TW = $clog2(TO_HALF + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TW_HALF - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_HALF - 1);
  typedef enum logic [1:0] {IDLE, HOUR, MIN, SEC} state_t;
  state_t r_state, w_ns;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to;
  logic w_adj, w_wrap, w_tout;
  logic [5:0] w_led;
  always_comb begin
    w_adj  = r_state != IDLE && (key_inc ^ key_dec) && !key_set;
    w_wrap = r_state != IDLE && r_cnt == CNT_MAX;
    // any accepted key restarts the window, so it also blocks the timeout
    w_tout = w_wrap && r_to == TO_MAX && !w_adj;
    w_ns   = key_set ? state_t'(r_state + 2'd1) : w_tout ? IDLE : r_state;
    w_led  = w_ns == HOUR ? 6'b110000 : w_ns == MIN ? 6'b001100 : w_ns == SEC ? 6'b000011 : 6'b000000;
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_to        <= '0;
      set_mode    <= 1'b0;
      adj_field   <= 2'b00;
      adj_up      <= 1'b0;
      adj_dn      <= 1'b0;
      twinkle     <= 1'b1;
      twinkle_led <= 6'b000000;
    end else begin
      r_state     <= w_ns;
      set_mode    <= w_ns != IDLE;
      adj_field   <= w_ns;
      twinkle_led <= w_led;
      adj_up      <= w_adj & key_inc;
      adj_dn      <= w_adj & key_dec;
      if (key_set || w_adj) begin
        r_cnt   <= '0;
        r_to    <= '0;
        twinkle <= w_ns == IDLE;
      end else if (w_tout || r_state == IDLE) begin
        r_cnt   <= '0;
        r_to    <= '0;
        twinkle <= 1'b1;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_to    <= r_to + 1'b1;
        twinkle <= ~twinkle;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_tw_ctrl.sv
// tb_tw_ctrl: scoreboard bench; stimulus queues expected output changes, monitor checks every change.
module tb_tw_ctrl;
  logic sysclk = 1'b0, rst_n, key_set, key_inc, key_dec;
  logic set_mode, adj_up, adj_dn, twinkle;
  logic [1:0] adj_field;
  logic [5:0] twinkle_led;
  logic [11:0] w_out;
  typedef struct {int c; logic [11:0] o;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  localparam logic [11:0] RST = 12'b0_00_0_0_1_000000;

  tw_ctrl #(.TW_HALF(4), .TO_HALF(6)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .key_set(key_set), .key_inc(key_inc), .key_dec(key_dec),
    .set_mode(set_mode), .adj_field(adj_field), .adj_up(adj_up), .adj_dn(adj_dn),
    .twinkle(twinkle), .twinkle_led(twinkle_led)
  );

  assign w_out = {set_mode, adj_field, adj_up, adj_dn, twinkle, twinkle_led};
  always #5 sysclk = ~sysclk;

  function automatic logic [11:0] mk(int s, bit up, bit dn, bit tw);
    logic [5:0] led;
    led = s == 1 ? 6'b110000 : s == 2 ? 6'b001100 : s == 3 ? 6'b000011 : 6'b000000;
    return {s != 0, 2'(s), up, dn, tw, led};
  endfunction

  task automatic push(int c, logic [11:0] o);
    q.push_back('{c, o});
  endtask

  task automatic pulse(bit s, bit i, bit d);
    key_set = s; key_inc = i; key_dec = d;
    @(negedge sysclk);
    key_set = 0; key_inc = 0; key_dec = 0;
  endtask

  task automatic check_now(string name, logic [11:0] exp);
    checks++;
    if (w_out !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, w_out, exp);
    end
  endtask

  initial begin : monitor
    logic [11:0] prev;
    exp_t e;
    prev = RST;
    forever begin
      @(posedge sysclk); #1;
      cyc++;
      if (w_out !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious change at cycle %0d: got %b was %b", cyc, w_out, prev);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.o !== w_out) begin
            errors++;
            $display("FAIL event: got %b at cycle %0d want %b at cycle %0d", w_out, cyc, e.o, e.c);
          end
        end
        prev = w_out;
      end
    end
  end

  initial begin
    int k, e;
    rst_n = 0; key_set = 0; key_inc = 0; key_dec = 0;
    repeat (3) @(negedge sysclk);
    check_now("reset", RST);
    rst_n = 1;
    repeat (50) @(negedge sysclk);
    pulse(0, 0, 1);
    repeat (10) @(negedge sysclk);
    check_now("idle_after_50_and_dec", RST);
    for (int s = 1; s <= 4; s++) begin
      @(negedge sysclk); k = cyc;
      push(k + 1, mk(s % 4, 0, 0, s == 4));
      if (s < 4) begin
        push(k + 5, mk(s, 0, 0, 1));
        push(k + 9, mk(s, 0, 0, 0));
      end
      pulse(1, 0, 0);
      repeat (8) @(negedge sysclk);
    end
    repeat (5) @(negedge sysclk);
    @(negedge sysclk); k = cyc;
    push(k + 1, mk(1, 0, 0, 0));
    for (int t = 1; t <= 5; t++) push(k + 1 + 4 * t, mk(1, 0, 0, t % 2));
    push(k + 25, mk(0, 0, 0, 1));
    pulse(1, 0, 0);
    repeat (30) @(negedge sysclk);
    @(negedge sysclk); k = cyc;
    push(k + 1, mk(1, 0, 0, 0));
    pulse(1, 0, 0);
    k = cyc;
    push(k + 1, mk(2, 0, 0, 0));
    e = k + 1;
    pulse(1, 0, 0);
    push(e + 4, mk(2, 0, 0, 1));
    repeat (5) @(negedge sysclk); k = cyc;
    push(k + 1, mk(2, 1, 0, 0));
    push(k + 2, mk(2, 0, 0, 0));
    for (int t = 1; t <= 5; t++) push(k + 1 + 4 * t, mk(2, 0, 0, t % 2));
    push(k + 25, mk(0, 0, 0, 1));
    pulse(0, 1, 0);
    repeat (30) @(negedge sysclk);
    @(negedge sysclk); k = cyc;
    push(k + 1, mk(1, 0, 0, 0));
    e = k + 1;
    pulse(1, 0, 0);
    push(e + 4, mk(1, 0, 0, 1));
    pulse(0, 1, 1);
    repeat (4) @(negedge sysclk);
    push(e + 6, mk(2, 0, 0, 0));
    pulse(1, 1, 0);
    push(e + 8, mk(2, 0, 1, 0));
    push(e + 9, mk(2, 0, 0, 0));
    @(negedge sysclk);
    pulse(0, 0, 1);
    @(negedge sysclk);
    push(e + 10, mk(3, 0, 0, 0));
    pulse(1, 0, 0);
    repeat (2) @(negedge sysclk);
    push(e + 13, RST);
    #1 rst_n = 0;
    #1 check_now("async_reset_mid_sec", RST);
    repeat (3) @(negedge sysclk);
    rst_n = 1;
    repeat (8) @(negedge sysclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left want 0 (next cycle %0d)", q.size(), q[0].c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
